// File: rtl/tb_mem_arb.sv
// Round-robin arbiter that serializes requesters onto one memory port and
// remaps upstream transaction IDs to internal slots of an outstanding table.
module tb_mem_arb #(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned TidWidth    = 2,
    parameter int unsigned MaxInflight = 4,
    localparam int unsigned SlotW = $clog2(MaxInflight),
    localparam int unsigned CntW  = $clog2(MaxInflight + 1),
    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           req_vld_i,
    output logic [NumPorts-1:0]           req_ack_o,
    input  logic [NumPorts-1:0]           req_we_i,
    input  logic [NumPorts*3-1:0]         req_size_i,
    input  logic [NumPorts*AddrWidth-1:0] req_paddr_i,
    input  logic [NumPorts*DataWidth-1:0] req_data_i,
    input  logic [NumPorts*TidWidth-1:0]  req_tid_i,
    output logic                          mem_req_o,
    input  logic                          mem_ack_i,
    output logic                          mem_we_o,
    output logic [2:0]                    mem_size_o,
    output logic [AddrWidth-1:0]          mem_paddr_o,
    output logic [DataWidth-1:0]          mem_data_o,
    output logic [SlotW-1:0]              mem_tid_o,
    input  logic                          mem_rtrn_vld_i,
    input  logic [1:0]                    mem_rtrn_type_i,
    input  logic [SlotW-1:0]              mem_rtrn_tid_i,
    input  logic [DataWidth-1:0]          mem_rtrn_data_i,
    output logic [NumPorts-1:0]           rtrn_vld_o,
    output logic [1:0]                    rtrn_type_o,
    output logic [TidWidth-1:0]           rtrn_tid_o,
    output logic [DataWidth-1:0]          rtrn_data_o,
    output logic [CntW-1:0]               inflight_cnt_o,
    output logic                          err_o
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                 state_q;
    logic [PortW-1:0]       rr_q;
    logic [MaxInflight-1:0] valid_q, valid_d;
    logic [PortW-1:0]       port_q [MaxInflight];
    logic [TidWidth-1:0]    tid_q  [MaxInflight];
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   err_q;

    logic                   mem_req_q, mem_we_q;
    logic [2:0]             mem_size_q;
    logic [AddrWidth-1:0]   mem_paddr_q;
    logic [DataWidth-1:0]   mem_data_q;
    logic [SlotW-1:0]       mem_tid_q;

    logic [NumPorts-1:0]    rtrn_vld_q;
    logic [1:0]             rtrn_type_q;
    logic [TidWidth-1:0]    rtrn_tid_q;
    logic [DataWidth-1:0]   rtrn_data_q;

    logic [PortW-1:0]       pidx, winner;
    logic                   win_found;
    logic [SlotW-1:0]       free_slot;
    logic                   free_found;
    logic                   grant;
    logic                   rtrn_hit;

    // Scan starts one past the last winner so the previous winner goes last.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        pidx      = '0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            pidx = PortW'((32'(rr_q) + i) % NumPorts);
            if (!win_found && req_vld_i[pidx]) begin
                winner    = pidx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        free_slot  = '0;
        free_found = 1'b0;
        for (int unsigned s = 0; s < MaxInflight; s++) begin
            if (!free_found && !valid_q[SlotW'(s)]) begin
                free_slot  = SlotW'(s);
                free_found = 1'b1;
            end
        end
    end

    assign grant    = (state_q == StIdle) && win_found && free_found;
    assign rtrn_hit = mem_rtrn_vld_i && !mem_rtrn_type_i[1] && valid_q[mem_rtrn_tid_i];

    always_comb begin
        req_ack_o = '0;
        if (grant) begin
            req_ack_o[winner] = 1'b1;
        end
    end

    // A slot being freed is still valid here, so it can never be the one allocated.
    always_comb begin
        valid_d = valid_q;
        if (grant) begin
            valid_d[free_slot] = 1'b1;
        end
        if (rtrn_hit) begin
            valid_d[mem_rtrn_tid_i] = 1'b0;
        end
        cnt_d = '0;
        for (int unsigned s = 0; s < MaxInflight; s++) begin
            cnt_d = cnt_d + CntW'(valid_d[SlotW'(s)]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rr_q        <= PortW'(NumPorts - 1);
            valid_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_paddr_q <= '0;
            mem_data_q  <= '0;
            mem_tid_q   <= '0;
            rtrn_vld_q  <= '0;
            rtrn_type_q <= '0;
            rtrn_tid_q  <= '0;
            rtrn_data_q <= '0;
            for (int unsigned s = 0; s < MaxInflight; s++) begin
                port_q[s] <= '0;
                tid_q[s]  <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            rtrn_vld_q <= '0;

            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        mem_req_q         <= 1'b1;
                        mem_we_q          <= req_we_i[winner];
                        mem_size_q        <= req_size_i[32'(winner)*3 +: 3];
                        mem_paddr_q       <= req_paddr_i[32'(winner)*AddrWidth +: AddrWidth];
                        mem_data_q        <= req_data_i[32'(winner)*DataWidth +: DataWidth];
                        mem_tid_q         <= free_slot;
                        port_q[free_slot] <= winner;
                        tid_q[free_slot]  <= req_tid_i[32'(winner)*TidWidth +: TidWidth];
                        rr_q              <= winner;
                        state_q           <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
            endcase

            if (mem_rtrn_vld_i) begin
                unique case (mem_rtrn_type_i)
                    2'd0, 2'd1: begin
                        if (valid_q[mem_rtrn_tid_i]) begin
                            rtrn_vld_q  <= NumPorts'(1) << port_q[mem_rtrn_tid_i];
                            rtrn_type_q <= mem_rtrn_type_i;
                            rtrn_tid_q  <= tid_q[mem_rtrn_tid_i];
                            rtrn_data_q <= mem_rtrn_data_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    2'd2: begin
                        rtrn_vld_q  <= '1;
                        rtrn_type_q <= 2'd2;
                        rtrn_tid_q  <= '0;
                        rtrn_data_q <= mem_rtrn_data_i;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_size_o     = mem_size_q;
    assign mem_paddr_o    = mem_paddr_q;
    assign mem_data_o     = mem_data_q;
    assign mem_tid_o      = mem_tid_q;
    assign rtrn_vld_o     = rtrn_vld_q;
    assign rtrn_type_o    = rtrn_type_q;
    assign rtrn_tid_o     = rtrn_tid_q;
    assign rtrn_data_o    = rtrn_data_q;
    assign inflight_cnt_o = cnt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_tb_mem_arb.sv
// Bench for tb_mem_arb: directed scenarios plus a randomized run against a
// slot-table reference model.
module tb_tb_mem_arb;
    localparam int NP = 2, AW = 64, DW = 128, TW = 2, MI = 4, SW = 2, CW = 3;

    logic clk, rst;
    logic [NP-1:0] req_vld, req_ack, req_we;
    logic [NP*3-1:0] req_size;
    logic [NP*AW-1:0] req_paddr;
    logic [NP*DW-1:0] req_data;
    logic [NP*TW-1:0] req_tid;
    logic mem_req, mem_ack, mem_we;
    logic [2:0] mem_size;
    logic [AW-1:0] mem_paddr;
    logic [DW-1:0] mem_data;
    logic [SW-1:0] mem_tid;
    logic mem_rtrn_vld;
    logic [1:0] mem_rtrn_type;
    logic [SW-1:0] mem_rtrn_tid;
    logic [DW-1:0] mem_rtrn_data;
    logic [NP-1:0] rtrn_vld;
    logic [1:0] rtrn_type;
    logic [TW-1:0] rtrn_tid;
    logic [DW-1:0] rtrn_data;
    logic [CW-1:0] cnt;
    logic err;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: outstanding table as plain arrays plus expected outputs.
    bit m_issue, m_err;
    int m_rr;
    bit m_valid[MI];
    int m_port[MI];
    logic [TW-1:0] m_tid[MI];
    logic [NP-1:0] e_rtrn_vld;
    logic [TW-1:0] e_rtrn_tid;
    logic [1:0] e_rtrn_type;
    logic [DW-1:0] e_rtrn_data;
    bit e_mem_req;
    int e_mem_tid, e_cnt;
    logic [AW-1:0] e_mem_paddr;

    tb_mem_arb dut (
        .clk_i(clk), .rst_i(rst),
        .req_vld_i(req_vld), .req_ack_o(req_ack), .req_we_i(req_we),
        .req_size_i(req_size), .req_paddr_i(req_paddr), .req_data_i(req_data),
        .req_tid_i(req_tid),
        .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_we_o(mem_we),
        .mem_size_o(mem_size), .mem_paddr_o(mem_paddr), .mem_data_o(mem_data),
        .mem_tid_o(mem_tid),
        .mem_rtrn_vld_i(mem_rtrn_vld), .mem_rtrn_type_i(mem_rtrn_type),
        .mem_rtrn_tid_i(mem_rtrn_tid), .mem_rtrn_data_i(mem_rtrn_data),
        .rtrn_vld_o(rtrn_vld), .rtrn_type_o(rtrn_type), .rtrn_tid_o(rtrn_tid),
        .rtrn_data_o(rtrn_data), .inflight_cnt_o(cnt), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic int model_free();
        for (int s = 0; s < MI; s++) if (!m_valid[s]) return s;
        return -1;
    endfunction

    function automatic int model_winner();
        if (m_issue || model_free() < 0) return -1;
        for (int k = 1; k <= NP; k++) begin
            if (req_vld[(m_rr + k) % NP]) return (m_rr + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] model_ack();
        int w;
        w = model_winner();
        return (w < 0) ? '0 : NP'(1 << w);
    endfunction

    // Advance one clock, applying the current inputs to the model first.
    task automatic tick();
        int w, f, freed;
        w = model_winner();
        f = model_free();
        freed = -1;
        if (rst) begin
            m_issue = 0; m_err = 0; m_rr = NP - 1;
            for (int s = 0; s < MI; s++) m_valid[s] = 0;
            e_rtrn_vld = '0; e_rtrn_tid = '0; e_rtrn_type = '0; e_rtrn_data = '0;
            e_mem_req = 0; e_mem_tid = 0; e_mem_paddr = '0; e_cnt = 0;
        end else begin
            e_rtrn_vld = '0;
            if (mem_rtrn_vld) begin
                if (mem_rtrn_type <= 2'd1) begin
                    if (m_valid[mem_rtrn_tid]) begin
                        e_rtrn_vld = NP'(1 << m_port[mem_rtrn_tid]);
                        e_rtrn_tid = m_tid[mem_rtrn_tid];
                        e_rtrn_type = mem_rtrn_type;
                        e_rtrn_data = mem_rtrn_data;
                        freed = int'(mem_rtrn_tid);
                    end else m_err = 1;
                end else if (mem_rtrn_type == 2'd2) begin
                    e_rtrn_vld = '1; e_rtrn_tid = '0; e_rtrn_type = 2'd2;
                    e_rtrn_data = mem_rtrn_data;
                end else m_err = 1;
            end
            if (m_issue) begin
                if (mem_ack) begin m_issue = 0; e_mem_req = 0; end
            end else if (w >= 0) begin
                m_valid[f] = 1; m_port[f] = w; m_tid[f] = req_tid[w*TW +: TW];
                e_mem_tid = f; e_mem_paddr = req_paddr[w*AW +: AW];
                m_issue = 1; e_mem_req = 1; m_rr = w;
            end
            if (freed >= 0) m_valid[freed] = 0;
            e_cnt = 0;
            for (int s = 0; s < MI; s++) e_cnt += int'(m_valid[s]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int p, bit v, bit we, logic [TW-1:0] tid, logic [AW-1:0] pa);
        req_vld[p] = v;
        req_we[p] = we;
        req_tid[p*TW +: TW] = tid;
        req_paddr[p*AW +: AW] = pa;
        req_size[p*3 +: 3] = 3'd4;
        req_data[p*DW +: DW] = {pa, ~pa};
    endtask

    task automatic ret(bit v, logic [1:0] ty, logic [SW-1:0] slot, logic [DW-1:0] d);
        mem_rtrn_vld = v; mem_rtrn_type = ty; mem_rtrn_tid = slot; mem_rtrn_data = d;
    endtask

    task automatic do_reset();
        rst = 1; req_vld = '0; mem_ack = 0;
        ret(0, 2'd0, '0, '0);
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        #3;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else n_pass++;
        n_checks++; if (req_ack !== 2'b00) $display("FAIL reset_ack got %b want 00", req_ack); else n_pass++;
        n_checks++; if (rtrn_vld !== 2'b00) $display("FAIL reset_rtrn_vld got %b want 00", rtrn_vld); else n_pass++;
        n_checks++; if (cnt !== 3'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        n_checks++; if (mem_paddr !== '0 || mem_tid !== '0) $display("FAIL reset_mem_bus got %h/%0d want 0/0", mem_paddr, mem_tid); else n_pass++;
        tick();
    endtask

    task automatic test_single_load();
        logic [DW-1:0] d;
        d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
        do_reset();
        set_req(0, 1, 0, 2'd2, 64'h1000);
        #3;
        n_checks++; if (req_ack !== 2'b01) $display("FAIL single_ack got %b want 01", req_ack); else n_pass++;
        tick();
        set_req(0, 0, 0, 2'd0, 64'h0);
        #3;
        n_checks++; if (mem_req !== 1'b1 || mem_tid !== 2'd0) $display("FAIL single_issue got req=%b tid=%0d want 1/0", mem_req, mem_tid); else n_pass++;
        n_checks++; if (mem_paddr !== 64'h1000 || mem_we !== 1'b0) $display("FAIL single_paddr got %h we=%b want 1000/0", mem_paddr, mem_we); else n_pass++;
        n_checks++; if (cnt !== 3'd1) $display("FAIL single_cnt1 got %0d want 1", cnt); else n_pass++;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        #3;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL single_req_drop got %b want 0", mem_req); else n_pass++;
        ret(1, 2'd0, 2'd0, d);
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (rtrn_vld !== 2'b01 || rtrn_tid !== 2'd2) $display("FAIL single_rtrn got vld=%b tid=%0d want 01/2", rtrn_vld, rtrn_tid); else n_pass++;
        n_checks++; if (rtrn_data !== d || rtrn_type !== 2'd0) $display("FAIL single_rdata got %h want %h", rtrn_data, d); else n_pass++;
        n_checks++; if (cnt !== 3'd0) $display("FAIL single_cnt0 got %0d want 0", cnt); else n_pass++;
        tick();
        #3;
        n_checks++; if (rtrn_vld !== 2'b00) $display("FAIL single_rtrn_pulse got %b want 00", rtrn_vld); else n_pass++;
        tick();
    endtask

    // Round robin fills the table; then table-full and same-cycle behaviour follow on.
    task automatic test_round_robin_full();
        logic [DW-1:0] d2, d3, d1;
        d2 = {4{32'h2222_0002}}; d3 = {4{32'h3333_0003}}; d1 = {4{32'h1111_0001}};
        do_reset();
        mem_ack = 1;
        set_req(0, 1, 0, 2'd1, 64'h100);
        set_req(1, 1, 1, 2'd3, 64'h200);
        for (int k = 0; k < 4; k++) begin
            #3;
            n_checks++; if (req_ack !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL rr_ack%0d got %b", k, req_ack); else n_pass++;
            tick();
            #3;
            n_checks++; if (mem_req !== 1'b1 || mem_tid !== SW'(k)) $display("FAIL rr_slot%0d got req=%b tid=%0d want 1/%0d", k, mem_req, mem_tid, k); else n_pass++;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            #3;
            n_checks++; if (req_ack !== 2'b00) $display("FAIL full_noack%0d got %b want 00", k, req_ack); else n_pass++;
            tick();
        end
        n_checks++; if (cnt !== 3'd4) $display("FAIL full_cnt got %0d want 4", cnt); else n_pass++;
        ret(1, 2'd1, 2'd2, d2);
        #3;
        n_checks++; if (req_ack !== 2'b00) $display("FAIL full_freed_same_cycle got %b want 00", req_ack); else n_pass++;
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (req_ack !== 2'b01) $display("FAIL full_regrant got %b want 01", req_ack); else n_pass++;
        n_checks++; if (rtrn_vld !== 2'b01 || rtrn_tid !== 2'd1 || rtrn_type !== 2'd1) $display("FAIL full_rtrn got vld=%b tid=%0d type=%0d want 01/1/1", rtrn_vld, rtrn_tid, rtrn_type); else n_pass++;
        n_checks++; if (cnt !== 3'd3) $display("FAIL full_cnt3 got %0d want 3", cnt); else n_pass++;
        tick();
        set_req(0, 0, 0, 2'd0, 64'h0);
        set_req(1, 0, 0, 2'd0, 64'h0);
        #3;
        n_checks++; if (mem_tid !== 2'd2 || cnt !== 3'd4) $display("FAIL full_slot2 got tid=%0d cnt=%0d want 2/4", mem_tid, cnt); else n_pass++;
        tick();
        // Same-cycle allocate and free.
        ret(1, 2'd0, 2'd3, d3);
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (cnt !== 3'd3 || rtrn_vld !== 2'b10) $display("FAIL same_pre got cnt=%0d vld=%b want 3/10", cnt, rtrn_vld); else n_pass++;
        set_req(1, 1, 0, 2'd2, 64'h300);
        ret(1, 2'd0, 2'd1, d1);
        #1;
        n_checks++; if (req_ack !== 2'b10) $display("FAIL same_ack got %b want 10", req_ack); else n_pass++;
        tick();
        ret(0, 2'd0, '0, '0);
        set_req(1, 0, 0, 2'd0, 64'h0);
        #3;
        n_checks++; if (mem_tid !== 2'd3) $display("FAIL same_slot got %0d want 3", mem_tid); else n_pass++;
        n_checks++; if (cnt !== 3'd3) $display("FAIL same_cnt got %0d want 3", cnt); else n_pass++;
        n_checks++; if (rtrn_vld !== 2'b10 || rtrn_tid !== 2'd3 || rtrn_data !== d1) $display("FAIL same_rtrn got vld=%b tid=%0d want 10/3", rtrn_vld, rtrn_tid); else n_pass++;
        tick();
        mem_ack = 0;
    endtask

    task automatic test_invalidate_err();
        logic [DW-1:0] di;
        di = {4{32'hA5A5_5A5A}};
        do_reset();
        ret(1, 2'd2, 2'd0, di);
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (rtrn_vld !== 2'b11 || rtrn_type !== 2'd2 || rtrn_tid !== 2'd0) $display("FAIL inv_rtrn got vld=%b type=%0d tid=%0d want 11/2/0", rtrn_vld, rtrn_type, rtrn_tid); else n_pass++;
        n_checks++; if (rtrn_data !== di || err !== 1'b0) $display("FAIL inv_data got %h err=%b", rtrn_data, err); else n_pass++;
        tick();
        #3;
        n_checks++; if (rtrn_vld !== 2'b00) $display("FAIL inv_pulse got %b want 00", rtrn_vld); else n_pass++;
        ret(1, 2'd0, 2'd3, di);
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (err !== 1'b1 || rtrn_vld !== 2'b00 || cnt !== 3'd0) $display("FAIL err_empty got err=%b vld=%b cnt=%0d want 1/00/0", err, rtrn_vld, cnt); else n_pass++;
        tick(); tick();
        #3;
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;
        tick();
        do_reset();
        #3;
        n_checks++; if (err !== 1'b0) $display("FAIL err_reset got %b want 0", err); else n_pass++;
        ret(1, 2'd3, 2'd0, di);
        tick();
        ret(0, 2'd0, '0, '0);
        #3;
        n_checks++; if (err !== 1'b1 || rtrn_vld !== 2'b00) $display("FAIL err_type3 got err=%b vld=%b want 1/00", err, rtrn_vld); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        ret(1, 2'd3, 2'd0, '0);
        tick();
        ret(0, 2'd0, '0, '0);
        set_req(0, 1, 0, 2'd1, 64'h40);
        tick();
        set_req(0, 0, 0, 2'd0, 64'h0);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        set_req(1, 1, 1, 2'd2, 64'h80);
        #3;
        n_checks++; if (req_ack !== 2'b10) $display("FAIL mid_ack got %b want 10", req_ack); else n_pass++;
        tick();
        set_req(1, 0, 0, 2'd0, 64'h0);
        #3;
        n_checks++; if (mem_req !== 1'b1 || cnt !== 3'd2 || err !== 1'b1) $display("FAIL mid_pre got req=%b cnt=%0d err=%b want 1/2/1", mem_req, cnt, err); else n_pass++;
        rst = 1;
        tick();
        rst = 0;
        #3;
        n_checks++; if (mem_req !== 1'b0 || cnt !== 3'd0 || err !== 1'b0) $display("FAIL mid_post got req=%b cnt=%0d err=%b want 0/0/0", mem_req, cnt, err); else n_pass++;
        tick();
        set_req(0, 1, 0, 2'd0, 64'h10);
        set_req(1, 1, 0, 2'd0, 64'h20);
        #3;
        n_checks++; if (req_ack !== 2'b01) $display("FAIL mid_first_grant got %b want 01", req_ack); else n_pass++;
        tick();
        req_vld = '0;
        mem_ack = 1;
        tick();
        mem_ack = 0;
    endtask

    task automatic test_random();
        logic [NP-1:0] acked;
        int live[$];
        int r;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_vld[p] && $urandom_range(0, 2) == 0)
                    set_req(p, 1, 1'($urandom), TW'($urandom), {$urandom, $urandom});
            end
            mem_ack = 1'($urandom_range(0, 1));
            live.delete();
            for (int s = 0; s < MI; s++) if (m_valid[s]) live.push_back(s);
            r = $urandom_range(0, 9);
            if (r < 5 && live.size() > 0)
                ret(1, 2'(r % 2), SW'(live[$urandom_range(0, live.size() - 1)]),
                    {$urandom, $urandom, $urandom, $urandom});
            else if (r == 5)
                ret(1, 2'd2, SW'($urandom), {$urandom, $urandom, $urandom, $urandom});
            else
                ret(0, 2'd0, '0, '0);
            #3;
            n_checks++; if (req_ack !== model_ack()) $display("FAIL rnd_ack c%0d got %b want %b", c, req_ack, model_ack()); else n_pass++;
            n_checks++; if (mem_req !== e_mem_req) $display("FAIL rnd_mem_req c%0d got %b want %b", c, mem_req, e_mem_req); else n_pass++;
            if (e_mem_req) begin
                n_checks++; if (mem_tid !== SW'(e_mem_tid) || mem_paddr !== e_mem_paddr) $display("FAIL rnd_mem_bus c%0d got %0d/%h want %0d/%h", c, mem_tid, mem_paddr, e_mem_tid, e_mem_paddr); else n_pass++;
            end
            n_checks++; if (cnt !== CW'(e_cnt)) $display("FAIL rnd_cnt c%0d got %0d want %0d", c, cnt, e_cnt); else n_pass++;
            n_checks++; if (rtrn_vld !== e_rtrn_vld) $display("FAIL rnd_rtrn_vld c%0d got %b want %b", c, rtrn_vld, e_rtrn_vld); else n_pass++;
            if (e_rtrn_vld != '0) begin
                n_checks++; if (rtrn_tid !== e_rtrn_tid || rtrn_type !== e_rtrn_type || rtrn_data !== e_rtrn_data) $display("FAIL rnd_rtrn_bus c%0d got %0d/%0d want %0d/%0d", c, rtrn_tid, rtrn_type, e_rtrn_tid, e_rtrn_type); else n_pass++;
            end
            n_checks++; if (err !== m_err) $display("FAIL rnd_err c%0d got %b want %b", c, err, m_err); else n_pass++;
            acked = req_ack;
            tick();
            for (int p = 0; p < NP; p++) if (acked[p]) req_vld[p] = 1'b0;
        end
        ret(0, 2'd0, '0, '0);
    endtask

    initial begin
        rst = 1; req_vld = '0; req_we = '0; req_size = '0; req_paddr = '0;
        req_data = '0; req_tid = '0; mem_ack = 0;
        mem_rtrn_vld = 0; mem_rtrn_type = '0; mem_rtrn_tid = '0; mem_rtrn_data = '0;
        #1;
        test_reset();
        test_single_load();
        test_round_robin_full();
        test_invalidate_err();
        test_reset_mid_issue();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tb_mem_arb.md
# tb_mem_arb

Round-robin arbiter and transaction-ID remapper sharing a single memory-emulation request/return port between `NumPorts` cache-side requesters in the write-through cache testbenches. It serializes requests onto the memory port, and replaces each requester's transaction ID with an internal slot ID from an outstanding-transaction table. Load and store acknowledgements are routed back to the issuing requester with its original ID restored. Invalidation returns are broadcast to every requester.

## Interface

Parameters:
- `NumPorts`, 2: number of upstream requesters, at least 2.
- `AddrWidth`, 64: physical address width.
- `DataWidth`, 128: request and return data width (one cache line).
- `TidWidth`, 2: upstream transaction-ID width.
- `MaxInflight`, 4: outstanding-table entries, a power of 2; `SlotW = $clog2(MaxInflight)`.

Ports:
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  clock.
  - `rst_i`  in  1  synchronous active-high reset.
- `req_vld_i`  in  NumPorts  per-port request valid; held until acked.
- `req_ack_o`  out  NumPorts  one-hot acceptance pulse.
- `req_we_i`  in  NumPorts  1 = store, 0 = load.
- `req_size_i`  in  NumPorts×3  transfer size.
- `req_paddr_i`  in  NumPorts×AddrWidth  address.
- `req_data_i`  in  NumPorts×DataWidth  store data.
- `req_tid_i`  in  NumPorts×TidWidth  upstream ID.
- `mem_req_o`  out  1  downstream request valid.
- `mem_ack_i`  in  1  downstream accept.
- `mem_we_o`, `mem_size_o`, `mem_paddr_o`, `mem_data_o`  out  1/3/AddrWidth/DataWidth  registered copy of the granted request.
- `mem_tid_o`  out  SlotW  allocated slot.
- `mem_rtrn_vld_i`  in  1  return valid.
- `mem_rtrn_type_i`  in  2  0 = load ack, 1 = store ack, 2 = invalidate, 3 = reserved.
- `mem_rtrn_tid_i`  in  SlotW  return slot.
- `mem_rtrn_data_i`  in  DataWidth  return payload.
- `rtrn_vld_o`  out  NumPorts  per-port return valid.
- `rtrn_type_o`, `rtrn_tid_o`, `rtrn_data_o`  out  2/TidWidth/DataWidth  shared return bus.
- `inflight_cnt_o`  out  $clog2(MaxInflight+1)  valid table entries.
- `err_o`  out  1  sticky protocol error.

## Operation

Request FSM has two states, IDLE and ISSUE.
- **IDLE**
  - Candidates are ports with `req_vld_i` set.
  - If any candidate exists and a table slot is free, the winner is the first candidate at or after `rr_q+1` (mod `NumPorts`).
  - Allocate the lowest-index free slot.
  - Assert `req_ack_o[winner]` combinationally.
  - Register the winner's we/size/paddr/data and the slot into the `mem_*` outputs.
  - Write the table entry (valid=1, port, upstream tid).
  - Set `rr_q` to the winner and go to ISSUE.
  - With no free slot, grant nothing and stay in IDLE.
- **ISSUE**
  - `mem_req_o = 1`; all `mem_*` outputs are held stable.
  - On `mem_ack_i`, return to IDLE.
  - No upstream ack is given while in ISSUE.

Return path (independent of the FSM):
- **Load or store ack (type 0/1)**
  - If `table[mem_rtrn_tid_i].valid`, register `rtrn_vld_o[port]=1`, `rtrn_tid_o` = stored tid, and type/data passthrough.
  - Clear the entry.
  - If the entry is not valid: set `err_o`, drop the return, leave the table unchanged.
- **Invalidate (type 2)**
  - Register `rtrn_vld_o` = all ones, `rtrn_type_o = 2`, data passthrough, `rtrn_tid_o = 0`.
  - The table is unchanged.
- **Type 3**: set `err_o`, drop the return.

Table and counter rules:
- Free-slot selection uses the table contents at the start of the cycle. A slot freed in cycle t is not allocatable until t+1.
- Allocate and free in the same cycle (different slots) are both applied; `inflight_cnt_o` is net unchanged.
- `inflight_cnt_o = popcount(valid)`, registered and consistent with the table.
- `err_o` clears only on reset.

Reset (synchronous, at any time including mid-ISSUE or with returns outstanding):
- FSM → IDLE; table cleared; `rr_q = NumPorts-1`, so port 0 has first priority.
- All outputs 0: `mem_req_o`, `req_ack_o`, `rtrn_vld_o`, `inflight_cnt_o`, `err_o`, and all `mem_*` and `rtrn_*` buses.
- Outstanding transactions are forgotten.

## Timing

- Grant in IDLE at cycle t: `req_ack_o` high in t; `mem_req_o` high from t+1 until and including the `mem_ack_i` cycle t+k.
- FSM is in IDLE at t+k+1; the next grant is possible at t+k+1. Peak throughput is one request per 2 cycles.
- Return at cycle t (`mem_rtrn_vld_i`): `rtrn_*` valid for exactly one cycle at t+1. The slot is free and the count updated at t+1.
- Returns are never back-pressured; one return per cycle is sustained.
- `req_ack_o` is the only combinational output. All others are registered.

## Test plan

- **Single load**: port 0 issues a load, tid 2, paddr 0x1000; memory acks 1 cycle later and returns slot 0 with data D.
  - `req_ack_o=01`, `mem_tid_o=0`, `inflight_cnt_o` 1→0.
  - `rtrn_vld_o=01`, `rtrn_tid_o=2`, `rtrn_data_o=D`.
- **Round-robin**: both ports hold valid continuously, with immediate `mem_ack_i`.
  - Grants alternate 0,1,0,1 every 2 cycles.
  - Slots allocate 0,1,2,3.
- **Table full**: 4 grants with no returns → no 5th grant and `req_ack_o` stays 0. Return slot 2 at t → grant at t+1 receives slot 2.
- **Same-cycle events**: a return freeing slot 1 coincides with a grant.
  - The grant takes a different free slot.
  - `inflight_cnt_o` is unchanged.
- **Invalidate and errors**:
  - Type-2 return → `rtrn_vld_o=11` for 1 cycle.
  - Type-0 return to an empty slot 3 → `err_o` high and stays high, no `rtrn_vld_o`.
- **Reset mid-ISSUE**: `rst_i` asserted while `mem_req_o=1` with 2 in flight → next cycle `mem_req_o=0`, `inflight_cnt_o=0`, `err_o=0`; the first grant after reset goes to port 0.
